// File: rtl/dmem_bus_if_pkg.sv
// Shared definitions for the data-side Wishbone master: FSM encoding and bus constants.
package dmem_bus_if_pkg;

    typedef enum logic [1:0] {
        DBUS_IDLE = 2'b00,
        DBUS_BUSY = 2'b01,
        DBUS_HOLD = 2'b10
    } dbus_state_e;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/dmem_bus_if.sv
// Data-side Wishbone classic master between the MEM stage and the data interconnect.
// Stalls the pipeline while a cycle is outstanding, parks read data during MEM stalls, aborts hung cycles.
module dmem_bus_if
    import dmem_bus_if_pkg::*;
#(
    parameter int STALL_BIT   = 4,
    parameter int TIMEOUT_CYC = 256,
    parameter int CNT_W       = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq,
    output logic        bus_err_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    dbus_state_e      state, state_nxt;
    logic [31:0]      rd_buf, rd_buf_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      adr_nxt, dat_nxt;
    logic             we_nxt, stb_nxt, cyc_nxt, err_nxt;
    logic [3:0]       sel_nxt;
    logic             mem_stalled;
    logic             timeout_hit;

    assign mem_stalled = stall_i[STALL_BIT];
    assign timeout_hit = (state == DBUS_BUSY) && !wb_ack_i && (cnt == CNT_LAST);

    always_comb begin
        state_nxt  = state;
        rd_buf_nxt = rd_buf;
        cnt_nxt    = cnt;
        adr_nxt    = wb_adr_o;
        dat_nxt    = wb_dat_o;
        we_nxt     = wb_we_o;
        sel_nxt    = wb_sel_o;
        stb_nxt    = wb_stb_o;
        cyc_nxt    = wb_cyc_o;
        err_nxt    = 1'b0;
        stallreq   = 1'b0;
        cpu_data_o = ZERO_WORD;

        case (state)
            DBUS_IDLE: begin
                stallreq = cpu_ce_i && !flush_i;
                if (cpu_ce_i && !flush_i) begin
                    adr_nxt   = cpu_addr_i;
                    dat_nxt   = cpu_data_i;
                    we_nxt    = cpu_we_i;
                    sel_nxt   = cpu_sel_i;
                    cyc_nxt   = 1'b1;
                    stb_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = DBUS_BUSY;
                end
            end
            DBUS_BUSY: begin
                stallreq = !wb_ack_i && !timeout_hit && !flush_i;
                // Read data is forwarded in the ack cycle so MEM can retire without an extra stall.
                if (wb_ack_i && !wb_we_o) begin
                    cpu_data_o = wb_dat_i;
                end
                if (flush_i) begin
                    cyc_nxt   = 1'b0;
                    stb_nxt   = 1'b0;
                    state_nxt = DBUS_IDLE;
                end else if (wb_ack_i) begin
                    cyc_nxt    = 1'b0;
                    stb_nxt    = 1'b0;
                    we_nxt     = 1'b0;
                    sel_nxt    = 4'b0000;
                    rd_buf_nxt = wb_we_o ? ZERO_WORD : wb_dat_i;
                    state_nxt  = mem_stalled ? DBUS_HOLD : DBUS_IDLE;
                end else if (timeout_hit) begin
                    cyc_nxt    = 1'b0;
                    stb_nxt    = 1'b0;
                    rd_buf_nxt = ZERO_WORD;
                    err_nxt    = 1'b1;
                    state_nxt  = mem_stalled ? DBUS_HOLD : DBUS_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DBUS_HOLD: begin
                // MEM is frozen with the request still asserted; replay the captured data, never re-issue.
                cpu_data_o = rd_buf;
                if (!mem_stalled) begin
                    state_nxt = DBUS_IDLE;
                end
            end
            default: begin
                state_nxt = DBUS_IDLE;
                cyc_nxt   = 1'b0;
                stb_nxt   = 1'b0;
            end
        endcase

        if (flush_i) begin
            state_nxt = DBUS_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DBUS_IDLE;
            rd_buf    <= ZERO_WORD;
            cnt       <= '0;
            wb_adr_o  <= ZERO_WORD;
            wb_dat_o  <= ZERO_WORD;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= 4'b0000;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            bus_err_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_buf    <= rd_buf_nxt;
            cnt       <= cnt_nxt;
            wb_adr_o  <= adr_nxt;
            wb_dat_o  <= dat_nxt;
            wb_we_o   <= we_nxt;
            wb_sel_o  <= sel_nxt;
            wb_stb_o  <= stb_nxt;
            wb_cyc_o  <= cyc_nxt;
            bus_err_o <= err_nxt;
        end
    end

endmodule

// File: tb/tb_dmem_bus_if.sv
// Directed bench for dmem_bus_if: expected bus completions are queued by the stimulus and
// checked by a monitor when the DUT sees an ack or raises bus_err_o.
module tb_dmem_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stallreq;
    logic        bus_err_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          err;
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    dmem_bus_if #(
        .STALL_BIT  (4),
        .TIMEOUT_CYC(4),
        .CNT_W      (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .cpu_ce_i  (cpu_ce_i),
        .cpu_we_i  (cpu_we_i),
        .cpu_addr_i(cpu_addr_i),
        .cpu_sel_i (cpu_sel_i),
        .cpu_data_i(cpu_data_i),
        .cpu_data_o(cpu_data_o),
        .stallreq  (stallreq),
        .bus_err_o (bus_err_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_we_o   (wb_we_o),
        .wb_sel_o  (wb_sel_o),
        .wb_stb_o  (wb_stb_o),
        .wb_cyc_o  (wb_cyc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic ce, input logic we, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] data);
        cpu_ce_i   = ce;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_sel_i  = sel;
        cpu_data_i = data;
    endtask

    task automatic push_txn(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                            input logic [31:0] dat, input logic [31:0] rdata);
        exp_t e;
        e.err = 1'b0; e.adr = adr; e.we = we; e.sel = sel; e.dat = dat; e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.err = 1'b1; e.adr = '0; e.we = 1'b0; e.sel = '0; e.dat = '0; e.rdata = '0;
        exp_q.push_back(e);
    endtask

    // Monitor: a completed bus transfer or an abort pulse consumes one expected entry.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if ((wb_cyc_o && wb_stb_o && wb_ack_i) || bus_err_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected: got cyc=%b ack=%b err=%b expected no event",
                             wb_cyc_o, wb_ack_i, bus_err_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("mon_kind", {31'd0, bus_err_o}, {31'd0, e.err});
                    if (e.err) begin
                        chk("mon_err_cyc", {31'd0, wb_cyc_o}, 32'd0);
                        chk("mon_err_data", cpu_data_o, 32'd0);
                    end else begin
                        chk("mon_adr", wb_adr_o, e.adr);
                        chk("mon_we", {31'd0, wb_we_o}, {31'd0, e.we});
                        chk("mon_sel", {28'd0, wb_sel_o}, {28'd0, e.sel});
                        if (e.we) chk("mon_wdat", wb_dat_o, e.dat);
                        chk("mon_rdata", cpu_data_o, e.rdata);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall_i = '0; flush_i = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0;
        req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        adv(); adv();
        settle();
        chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        chk("rst_err", {31'd0, bus_err_o}, 32'd0);
        chk("rst_stallreq", {31'd0, stallreq}, 32'd0);
        adv();
        rst = 1'b0;
        adv();

        // LW 0x10, one wait state
        req(1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
        push_txn(32'h10, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF);
        settle(); chk("lw_stall_req", {31'd0, stallreq}, 32'd1); adv();
        settle();
        chk("lw_stall_busy", {31'd0, stallreq}, 32'd1);
        chk("lw_stb", {31'd0, wb_stb_o}, 32'd1);
        chk("lw_data_wait", cpu_data_o, 32'd0);
        adv();
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        settle();
        chk("lw_stall_ack", {31'd0, stallreq}, 32'd0);
        chk("lw_fwd", cpu_data_o, 32'hDEAD_BEEF);
        adv();

        // SB 0x13 back-to-back
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        req(1'b1, 1'b1, 32'h0000_0013, 4'b0001, 32'h5A5A_5A5A);
        push_txn(32'h13, 1'b1, 4'b0001, 32'h5A5A_5A5A, 32'h0);
        settle();
        chk("sb_cyc_dropped", {31'd0, wb_cyc_o}, 32'd0);
        chk("sb_sel_cleared", {28'd0, wb_sel_o}, 32'd0);
        chk("sb_stall_req", {31'd0, stallreq}, 32'd1);
        adv();
        settle();
        chk("sb_we", {31'd0, wb_we_o}, 32'd1);
        chk("sb_sel", {28'd0, wb_sel_o}, 32'd1);
        adv();
        wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
        settle(); chk("sb_data_ack", cpu_data_o, 32'd0); adv();
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        settle();
        chk("sb_cyc_after", {31'd0, wb_cyc_o}, 32'd0);
        chk("sb_we_after", {31'd0, wb_we_o}, 32'd0);
        chk("sb_data_after", cpu_data_o, 32'd0);
        adv();

        // Read acked under MEM stall -> HOLD
        req(1'b1, 1'b0, 32'h0000_0020, 4'hF, 32'h0);
        push_txn(32'h20, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D);
        adv(); adv();
        wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D; stall_i = 6'b011111;
        adv();
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("hold_data", cpu_data_o, 32'hCAFE_F00D);
            chk("hold_stallreq", {31'd0, stallreq}, 32'd0);
            chk("hold_cyc", {31'd0, wb_cyc_o}, 32'd0);
            adv();
        end
        stall_i = 6'b000000;
        settle(); chk("hold_last_data", cpu_data_o, 32'hCAFE_F00D); adv();
        req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        settle();
        chk("hold_exit_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("hold_exit_data", cpu_data_o, 32'd0);
        adv();

        // Flush in second BUSY cycle
        req(1'b1, 1'b0, 32'h0000_0030, 4'hF, 32'h0);
        adv();
        settle(); chk("fl_busy_cyc", {31'd0, wb_cyc_o}, 32'd1); adv();
        flush_i = 1'b1;
        settle(); chk("fl_stallreq", {31'd0, stallreq}, 32'd0); adv();
        flush_i = 1'b0;
        req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        wb_ack_i = 1'b1; wb_dat_i = 32'hBADB_AD00;
        settle();
        chk("fl_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("fl_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("fl_late_ack_data", cpu_data_o, 32'd0);
        adv();
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;

        // Flush in the request cycle of a write
        req(1'b1, 1'b1, 32'h0000_0060, 4'hF, 32'hFFFF_FFFF);
        flush_i = 1'b1;
        settle(); chk("flreq_stallreq", {31'd0, stallreq}, 32'd0); adv();
        flush_i = 1'b0;
        req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        settle();
        chk("flreq_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("flreq_we", {31'd0, wb_we_o}, 32'd0);
        adv();

        // Timeout with MEM stalled: rd_buf must be cleared
        req(1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'h0);
        push_err();
        adv();
        for (int i = 0; i < 3; i++) begin
            settle(); chk("to_stallreq_wait", {31'd0, stallreq}, 32'd1); adv();
        end
        stall_i = 6'b011111;
        settle(); chk("to_stallreq_hit", {31'd0, stallreq}, 32'd0); adv();
        settle(); chk("to_err_pulse", {31'd0, bus_err_o}, 32'd1); adv();
        stall_i = 6'b000000;
        settle();
        chk("to_err_cleared", {31'd0, bus_err_o}, 32'd0);
        chk("to_hold_data", cpu_data_o, 32'd0);
        adv();
        req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        settle(); chk("to_idle_cyc", {31'd0, wb_cyc_o}, 32'd0); adv();

        // Reset mid-BUSY
        req(1'b1, 1'b1, 32'h0000_0050, 4'hF, 32'h1122_3344);
        adv();
        rst = 1'b1;
        adv();
        rst = 1'b0;
        settle();
        chk("rr_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rr_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("rr_we", {31'd0, wb_we_o}, 32'd0);
        chk("rr_adr", wb_adr_o, 32'd0);
        chk("rr_dat", wb_dat_o, 32'd0);
        chk("rr_stallreq", {31'd0, stallreq}, 32'd1);
        push_txn(32'h50, 1'b1, 4'hF, 32'h1122_3344, 32'h0);
        adv();
        adv();
        wb_ack_i = 1'b1;
        adv();
        wb_ack_i = 1'b0;
        req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        settle(); chk("rr_done_cyc", {31'd0, wb_cyc_o}, 32'd0); adv();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
